pipe_ctrl_skid_stage: RTL and testbench

//   Parametrised pipeline-stage control register with an N-entry skid buffer.

---
 rtl/pipe_ctrl_skid_stage.sv | 196 +++++++++++++++++++
 tb/tb_pipe_ctrl_skid_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_skid_stage.sv
// Purpose : stage k -> k+1 control-bundle register with an N-entry skid buffer for hazard stalls.
// Latency : 1 cycle in RUN; queued bundles replay in order, one per cycle, once HOLD drops.
// Backpr. : hold_up_o = hold_i & skid full; a valid bundle arriving while full is dropped and sets ovf_o.
// Optional: define PIPE_CTRL_STATS_EN to add hold_cyc_o, a saturating count of held cycles.
module pipe_ctrl_skid_stage #(
   parameter int unsigned       CTRL_W     = 21,
   // {ALU=4'hF, SH=0, M=0, T=0, C=6'b100011}: the encoding downstream treats as "do nothing"
   parameter logic [CTRL_W-1:0] NOP_WORD   = {4'hF, 2'b00, 2'b00, 7'b0000000, 6'b100011},
   // legal range 1..16; occupancy is reported on a 5-bit port
   parameter int unsigned       SKID_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [CTRL_W-1:0] ctrl_in_i,
   input  logic              in_valid_i,
   input  logic              hold_i,
   input  logic              flush_i,
`ifdef PIPE_CTRL_STATS_EN
   output logic [15:0]       hold_cyc_o,
`endif
   output logic [CTRL_W-1:0] ctrl_out_o,
   output logic              out_valid_o,
   output logic              hold_up_o,
   output logic [4:0]        skid_cnt_o,
   output logic              ovf_o
);

   // Pointer width; a depth of 1 still needs a (constant-zero) 1-bit pointer.
   localparam int unsigned PTR_W   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);
   localparam logic [4:0]  DEPTH_C = 5'(SKID_DEPTH);

   // Operating mode is purely a view of (hold_i, occupancy); it carries no state of its own.
   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,   // nothing queued, not held: straight-through register
      MODE_HELD  = 2'd1,   // stall: NOP downstream, absorb valid inputs into the skid
      MODE_DRAIN = 2'd2    // not held but work queued: replay the oldest entry
   } mode_e;

   // Skid storage and circular-FIFO bookkeeping (pointers wrap at SKID_DEPTH, not at 2^PTR_W).
   logic [CTRL_W-1:0] skid_q [SKID_DEPTH];
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [4:0]        cnt_q, cnt_d;

   // Registered outputs.
   logic [CTRL_W-1:0] ctrl_out_q, ctrl_out_d;
   logic              out_valid_q, out_valid_d;
   logic              ovf_q, ovf_d;

   // Per-edge actions decided by the control process.
   logic              push;
   logic              pop;
   logic              skid_full;
   logic              skid_empty;
   mode_e             mode;

   // Wrap-around increment for the skid pointers.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == LAST_PTR) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   assign skid_full  = (cnt_q == DEPTH_C);
   assign skid_empty = (cnt_q == 5'd0);

   // Derive the current mode from HOLD and occupancy.
   always_comb begin
      mode = MODE_RUN;
      if (hold_i) begin
         mode = MODE_HELD;
      end else if (!skid_empty) begin
         mode = MODE_DRAIN;
      end
   end

   // Next-state / output decision; FLUSH overrides every mode.
   always_comb begin
      ctrl_out_d  = NOP_WORD;
      out_valid_d = 1'b0;
      ovf_d       = ovf_q;
      push        = 1'b0;
      pop         = 1'b0;
      rd_d        = rd_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;

      if (flush_i) begin
         // Squash: queued work and the incoming bundle are discarded, OVF history survives.
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = 5'd0;
      end else begin
         unique case (mode)
            MODE_HELD: begin
               // Downstream sees NOP; incoming ops are parked, or lost if upstream ignored HOLD_UP.
               if (in_valid_i) begin
                  if (skid_full) begin
                     ovf_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end
            end
            MODE_DRAIN: begin
               // Oldest entry goes out first; a new op joins the tail on the same edge,
               // which is legal even when full because the pop frees a slot.
               ctrl_out_d  = skid_q[rd_q];
               out_valid_d = 1'b1;
               pop         = 1'b1;
               push        = in_valid_i;
            end
            default: begin
               // RUN: plain pipeline register; invalid cycles become NOP.
               if (in_valid_i) begin
                  ctrl_out_d  = ctrl_in_i;
                  out_valid_d = 1'b1;
               end
            end
         endcase

         if (push) begin
            wr_d = ptr_inc(wr_q);
         end
         if (pop) begin
            rd_d = ptr_inc(rd_q);
         end
         cnt_d = cnt_q + {4'd0, push} - {4'd0, pop};
      end
   end

   // Skid storage: only the slot at the write pointer changes, and only on a push.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            skid_q[i] <= NOP_WORD;
         end
      end else if (push && !flush_i) begin
         skid_q[wr_q] <= ctrl_in_i;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= 5'd0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Output register and sticky overflow flag.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_out_q  <= NOP_WORD;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         ctrl_out_q  <= ctrl_out_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef PIPE_CTRL_STATS_EN
   logic [15:0] hold_cyc_q;

   // Saturating count of held edges; FLUSH does not clear it, only reset does.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hold_cyc_q <= 16'd0;
      end else if (hold_i && (hold_cyc_q != 16'hFFFF)) begin
         hold_cyc_q <= hold_cyc_q + 16'd1;
      end
   end

   assign hold_cyc_o = hold_cyc_q;
`endif

   // Backpressure only matters while held: a draining stage always frees a slot each edge.
   assign hold_up_o   = hold_i & skid_full;
   assign ctrl_out_o  = ctrl_out_q;
   assign out_valid_o = out_valid_q;
   assign skid_cnt_o  = cnt_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipe_ctrl_skid_stage.sv
// Purpose : directed + randomized check of pipe_ctrl_skid_stage against a queue-based reference model.
// Latency : model predicts outputs one edge after inputs are applied.
// Backpr. : hold_up checked each cycle before the edge; drops while full must set ovf.
module tb_pipe_ctrl_skid_stage;

   localparam int unsigned W = 21;
   localparam int unsigned D = 2;
   localparam logic [W-1:0] NOP = 21'h1E0023;
   localparam logic [W-1:0] A   = 21'h012345;
   localparam logic [W-1:0] B   = 21'h006789;
   localparam logic [W-1:0] C   = 21'h01ABCD;

   logic           clk;
   logic           rst_n;
   logic [W-1:0]   ctrl_in;
   logic           in_valid;
   logic           hold;
   logic           flush;
   logic [W-1:0]   ctrl_out;
   logic           out_valid;
   logic           hold_up;
   logic [4:0]     skid_cnt;
   logic           ovf;
`ifdef PIPE_CTRL_STATS_EN
   logic [15:0]    hold_cyc;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a bounded queue of pending ops plus the last issued output.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_out;
   logic         m_vld;
   logic         m_ovf;
   int           m_hc;

   pipe_ctrl_skid_stage #(.CTRL_W(W), .NOP_WORD(NOP), .SKID_DEPTH(D)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .ctrl_in_i   (ctrl_in),
      .in_valid_i  (in_valid),
      .hold_i      (hold),
      .flush_i     (flush),
`ifdef PIPE_CTRL_STATS_EN
      .hold_cyc_o  (hold_cyc),
`endif
      .ctrl_out_o  (ctrl_out),
      .out_valid_o (out_valid),
      .hold_up_o   (hold_up),
      .skid_cnt_o  (skid_cnt),
      .ovf_o       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_out = NOP;
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_hc  = 0;
   endtask

   // Behaviour of one rising edge, straight from the priority rules.
   task automatic model_edge(input logic h, input logic v, input logic f, input logic [W-1:0] d);
      if (h && m_hc < 65535) m_hc++;
      if (f) begin
         mq.delete();
         m_out = NOP;
         m_vld = 1'b0;
      end else if (h) begin
         m_out = NOP;
         m_vld = 1'b0;
         if (v) begin
            if (mq.size() < D) mq.push_back(d);
            else m_ovf = 1'b1;
         end
      end else if (mq.size() == 0) begin
         m_out = v ? d : NOP;
         m_vld = v;
      end else begin
         m_out = mq.pop_front();
         m_vld = 1'b1;
         if (v) mq.push_back(d);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".ctrl_out"},  32'(ctrl_out),  32'(m_out));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
      chk({tag, ".skid_cnt"},  32'(skid_cnt),  32'(mq.size()));
      chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
`ifdef PIPE_CTRL_STATS_EN
      chk({tag, ".hold_cyc"},  32'(hold_cyc),  32'(m_hc));
`endif
   endtask

   // One cycle: drive, check backpressure before the edge, advance model, check outputs after.
   task automatic cyc(input string tag, input logic h, input logic v, input logic f,
                      input logic [W-1:0] d);
      hold     = h;
      in_valid = v;
      flush    = f;
      ctrl_in  = d;
      #2;
      chk({tag, ".hold_up"}, 32'(hold_up), 32'(h && (mq.size() == D)));
      @(posedge clk);
      model_edge(h, v, f, d);
      #1;
      chk_model(tag);
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] d, input logic v,
                             input logic [4:0] cnt);
      chk({tag, ".dir_out"}, 32'(ctrl_out),  32'(d));
      chk({tag, ".dir_vld"}, 32'(out_valid), 32'(v));
      chk({tag, ".dir_cnt"}, 32'(skid_cnt),  32'(cnt));
   endtask

   // Asynchronous reset applied away from a clock edge; outputs must clear immediately.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      expect_out(tag, NOP, 1'b0, 5'd0);
      chk({tag, ".ovf"}, 32'(ovf), 32'd0);
      hold = 1'b0; in_valid = 1'b0; flush = 1'b0; ctrl_in = '0;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; hold = 1'b0; in_valid = 1'b0; flush = 1'b0; ctrl_in = '0;
      model_reset();
      #1;
      rst_n = 1'b0;
      #1;
      expect_out("reset", NOP, 1'b0, 5'd0);
      chk("reset.ovf", 32'(ovf), 32'd0);
      chk("reset.hold_up", 32'(hold_up), 32'd0);
      #20;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef PIPE_CTRL_STATS_EN
      for (int i = 0; i < 5; i++) cyc("S5", 1'b1, 1'b0, 1'b0, '0);
      chk("S5.hold_cyc", 32'(hold_cyc), 32'd5);
      cyc("S5.flush", 1'b0, 1'b0, 1'b1, '0);
      chk("S5.flush_keep", 32'(hold_cyc), 32'd5);
      do_reset("S_rst");
`endif

      // T1: straight-through, one cycle latency
      cyc("T1a", 1'b0, 1'b1, 1'b0, A); expect_out("T1a", A, 1'b1, 5'd0);
      cyc("T1b", 1'b0, 1'b1, 1'b0, B); expect_out("T1b", B, 1'b1, 5'd0);
      cyc("T1c", 1'b0, 1'b1, 1'b0, C); expect_out("T1c", C, 1'b1, 5'd0);
      cyc("T1d", 1'b0, 1'b0, 1'b0, A); expect_out("T1d", NOP, 1'b0, 5'd0);

      // T2: hold two cycles, release with C
      cyc("T2a", 1'b1, 1'b1, 1'b0, A); expect_out("T2a", NOP, 1'b0, 5'd1);
      cyc("T2b", 1'b1, 1'b1, 1'b0, B); expect_out("T2b", NOP, 1'b0, 5'd2);
      cyc("T2c", 1'b0, 1'b1, 1'b0, C); expect_out("T2c", A, 1'b1, 5'd2);
      cyc("T2d", 1'b0, 1'b0, 1'b0, '0); expect_out("T2d", B, 1'b1, 5'd1);
      cyc("T2e", 1'b0, 1'b0, 1'b0, '0); expect_out("T2e", C, 1'b1, 5'd0);
      chk("T2.ovf", 32'(ovf), 32'd0);

      // T3: overflow when upstream ignores HOLD_UP
      cyc("T3a", 1'b1, 1'b1, 1'b0, A);
      cyc("T3b", 1'b1, 1'b1, 1'b0, B);
      chk("T3.hold_up", 32'(hold_up), 32'd1);
      cyc("T3c", 1'b1, 1'b1, 1'b0, C); expect_out("T3c", NOP, 1'b0, 5'd2);
      chk("T3.ovf", 32'(ovf), 32'd1);
      cyc("T3d", 1'b0, 1'b0, 1'b0, '0); expect_out("T3d", A, 1'b1, 5'd1);
      cyc("T3e", 1'b0, 1'b0, 1'b0, '0); expect_out("T3e", B, 1'b1, 5'd0);
      cyc("T3f", 1'b0, 1'b0, 1'b0, '0); expect_out("T3f", NOP, 1'b0, 5'd0);

      // T4: flush discards queued work, OVF survives
      cyc("T4a", 1'b1, 1'b1, 1'b0, A);
      cyc("T4b", 1'b1, 1'b1, 1'b0, B);
      cyc("T4c", 1'b0, 1'b1, 1'b1, C); expect_out("T4c", NOP, 1'b0, 5'd0);
      chk("T4.ovf", 32'(ovf), 32'd1);

      // T5: hold re-asserted mid-drain, then reset mid-drain
      do_reset("T5_rst0");
      cyc("T5a", 1'b1, 1'b1, 1'b0, A);
      cyc("T5b", 1'b1, 1'b1, 1'b0, B);
      cyc("T5c", 1'b0, 1'b0, 1'b0, '0); expect_out("T5c", A, 1'b1, 5'd1);
      cyc("T5d", 1'b1, 1'b0, 1'b0, '0); expect_out("T5d", NOP, 1'b0, 5'd1);
      cyc("T5e", 1'b0, 1'b0, 1'b0, '0); expect_out("T5e", B, 1'b1, 5'd0);
      cyc("T5f", 1'b1, 1'b1, 1'b0, A);
      cyc("T5g", 1'b1, 1'b1, 1'b0, B);
      cyc("T5h", 1'b0, 1'b0, 1'b0, '0); expect_out("T5h", A, 1'b1, 5'd1);
      do_reset("T5_rst");

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic h, v, f;
         h = ($urandom_range(0, 99) < 40);
         v = ($urandom_range(0, 99) < 70);
         f = ($urandom_range(0, 99) < 5);
         cyc("RND", h, v, f, W'($urandom));
      end

`ifdef PIPE_CTRL_STATS_EN
      // Saturation of the hold counter
      do_reset("S_rst2");
      while (m_hc < 16'hFFFE) cyc("SAT", 1'b1, 1'b0, 1'b0, '0);
      chk("SAT.fffe", 32'(hold_cyc), 32'hFFFE);
      for (int i = 0; i < 3; i++) cyc("SAT3", 1'b1, 1'b0, 1'b0, '0);
      chk("SAT.ffff", 32'(hold_cyc), 32'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
